// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands one cipher key into 11 round keys, one per clock,
// and holds them in a buffer that can be read combinationally by round index.
module aes_key_expand (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [3:0]   rk_addr_i,
    output logic [127:0] rk_o,
    output logic         busy_o,
    output logic         keys_valid_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t         state;
    state_t         state_next;
    logic [3:0]     round_cnt;
    logic [7:0]     rcon;
    logic [127:0]   rk_mem [11];
    logic           busy;
    logic           keys_valid;
    logic           load_key;
    logic           step_round;
    logic           last_round;
    logic [127:0]   prev_key;
    logic [127:0]   new_key;

    // Entry x sits (255-x) bytes above bit 0, i.e. at bit offset {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] pos;
        pos = {~x, 3'b000};
        return SBOX_TABLE[pos +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h000000};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_key   = 1'b0;
        step_round = 1'b0;
        last_round = (round_cnt == LAST_ROUND);
        case (state)
            IDLE, READY: begin
                if (start_i) begin
                    load_key   = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                step_round = 1'b1;
                if (last_round) begin
                    state_next = READY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The key derived this cycle always comes from the entry just below the counter.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < 10; i++) begin
            if (round_cnt == 4'(i + 1)) begin
                prev_key = rk_mem[i];
            end
        end
    end

    assign new_key = next_round_key(prev_key, rcon);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            round_cnt  <= '0;
            rcon       <= 8'h01;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                rk_mem[i] <= '0;
            end
        end else if (load_key) begin
            rk_mem[0]  <= key_i;
            round_cnt  <= 4'd1;
            rcon       <= 8'h01;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
        end else if (step_round) begin
            for (int i = 1; i < 11; i++) begin
                if (round_cnt == 4'(i)) begin
                    rk_mem[i] <= new_key;
                end
            end
            // Counter parks at the last round rather than running past it.
            if (last_round) begin
                busy       <= 1'b0;
                keys_valid <= 1'b1;
            end else begin
                round_cnt <= round_cnt + 4'd1;
                rcon      <= xtime(rcon);
            end
        end
    end

    always_comb begin
        rk_o = '0;
        for (int i = 0; i < 11; i++) begin
            if (rk_addr_i == 4'(i)) begin
                rk_o = rk_mem[i];
            end
        end
    end

    assign busy_o       = busy;
    assign keys_valid_o = keys_valid;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a word-oriented FIPS-197 key schedule
// whose S-box is derived from GF(2^8) inversion plus the affine transform.
module tb_aes_key_expand;

    logic         clock_i;
    logic         reset_i;
    logic         start_i;
    logic [127:0] key_i;
    logic [3:0]   rk_addr_i;
    logic [127:0] rk_o;
    logic         busy_o;
    logic         keys_valid_o;

    int           assertCount;
    int           failCount;
    logic [127:0] modelKeys [11];

    localparam logic [127:0] NIST_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] NIST_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] NIST_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_expand dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .key_i        (key_i),
        .rk_addr_i    (rk_addr_i),
        .rk_o         (rk_o),
        .busy_o       (busy_o),
        .keys_valid_o (keys_valid_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(a, 8'(y)) == 8'h01) return 8'(y);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] sboxModel(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Classic w[i] = w[i-4] ^ temp formulation over all 44 words.
    task automatic computeModel(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sboxModel(temp[31:24]), sboxModel(temp[23:16]),
                        sboxModel(temp[15:8]), sboxModel(temp[7:0])} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) modelKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] randomKey();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic sweepZero(input string tag);
        for (int a = 0; a < 16; a++) begin
            rk_addr_i = 4'(a);
            #1;
            checkOutput($sformatf("%s_addr%0d", tag, a), rk_o, 128'h0);
        end
    endtask

    task automatic checkAllKeys(input string tag);
        for (int a = 0; a < 16; a++) begin
            rk_addr_i = 4'(a);
            #1;
            checkOutput($sformatf("%s_addr%0d", tag, a), rk_o, (a <= 10) ? modelKeys[a] : 128'h0);
        end
    endtask

    // Starts an expansion and tracks it edge by edge; optionally re-pulses start with a
    // different key in cycle 4 and scrambles key_i throughout to show both are ignored.
    task automatic applyStimulus(input string tag, input logic [127:0] key, input bit inject);
        computeModel(key);
        @(negedge clock_i);
        start_i = 1'b1;
        key_i   = key;
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        key_i   = randomKey();
        checkFlag({tag, "_accept_busy"}, busy_o, 1'b1);
        checkFlag({tag, "_accept_valid"}, keys_valid_o, 1'b0);
        rk_addr_i = 4'd0;
        #1;
        checkOutput({tag, "_rk0_loaded"}, rk_o, modelKeys[0]);
        for (int e = 1; e <= 10; e++) begin
            if (inject && e == 4) begin
                start_i = 1'b1;
                key_i   = randomKey();
            end
            @(posedge clock_i);
            #1;
            start_i = 1'b0;
            key_i   = randomKey();
            checkFlag($sformatf("%s_busy_e%0d", tag, e), busy_o, e < 10);
            checkFlag($sformatf("%s_valid_e%0d", tag, e), keys_valid_o, e == 10);
            rk_addr_i = 4'(e);
            #1;
            checkOutput($sformatf("%s_partial_rk%0d", tag, e), rk_o, modelKeys[e]);
        end
        checkAllKeys({tag, "_sweep"});
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset_i     = 1'b1;
        start_i     = 1'b1;
        key_i       = randomKey();
        rk_addr_i   = 4'd0;

        $display("[TB] reset with start held high");
        repeat (3) @(posedge clock_i);
        #1;
        checkFlag("reset_busy", busy_o, 1'b0);
        checkFlag("reset_valid", keys_valid_o, 1'b0);
        sweepZero("reset_rk");
        @(negedge clock_i);
        start_i = 1'b0;
        reset_i = 1'b0;
        @(posedge clock_i);
        #1;
        checkFlag("idle_busy", busy_o, 1'b0);
        checkFlag("idle_valid", keys_valid_o, 1'b0);

        $display("[TB] FIPS-197 appendix key");
        applyStimulus("nist", NIST_KEY, 1'b0);
        rk_addr_i = 4'd1;
        #1;
        checkOutput("nist_rk1_const", rk_o, NIST_RK1);
        rk_addr_i = 4'd10;
        #1;
        checkOutput("nist_rk10_const", rk_o, NIST_RK10);

        $display("[TB] all-zero key restarted from READY");
        applyStimulus("zero", 128'h0, 1'b0);
        rk_addr_i = 4'd1;
        #1;
        checkOutput("zero_rk1_const", rk_o, ZERO_RK1);
        rk_addr_i = 4'd10;
        #1;
        checkOutput("zero_rk10_const", rk_o, ZERO_RK10);

        $display("[TB] start re-pulsed during expansion");
        applyStimulus("inject", randomKey(), 1'b1);

        $display("[TB] reset in cycle 5 of expansion");
        @(negedge clock_i);
        start_i = 1'b1;
        key_i   = randomKey();
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clock_i);
        #2;
        reset_i = 1'b1;
        #1;
        checkFlag("abort_busy", busy_o, 1'b0);
        checkFlag("abort_valid", keys_valid_o, 1'b0);
        sweepZero("abort_rk");
        @(negedge clock_i);
        reset_i = 1'b0;
        applyStimulus("after_abort", NIST_KEY, 1'b0);
        rk_addr_i = 4'd10;
        #1;
        checkOutput("after_abort_rk10_const", rk_o, NIST_RK10);

        $display("[TB] random keys");
        for (int n = 0; n < 4; n++) begin
            applyStimulus($sformatf("rand%0d", n), randomKey(), n[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
